// File: rtl/elevator_controller.sv
// Single-car elevator controller: latches floor calls, serves them with a
// SCAN sweep, and times floor-to-floor travel and the door dwell.
module elevator_controller #(
  parameter int unsigned FLOORS        = 10,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [FLOORS-1:0]         req,
  output logic [$clog2(FLOORS)-1:0] floor,
  output logic                      moving_up,
  output logic                      moving_down,
  output logic                      door_open,
  output logic [FLOORS-1:0]         pending,
  output logic                      arrive,
  output logic                      done
);

  localparam int unsigned FW   = $clog2(FLOORS);
  localparam int unsigned MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

  state_t            state, state_n;
  logic              dir_up, dir_up_n;
  logic [TW-1:0]     timer, timer_n;
  logic [FW-1:0]     floor_n;
  logic              arrive_n;
  logic [FLOORS-1:0] pr, svc, pending_n;
  logic              above, below, hit_up, hit_dn;
  logic              travel_end, door_end;

  assign travel_end = (timer == TW'(TRAVEL_CYCLES - 1));
  assign door_end   = (timer == TW'(DOOR_CYCLES - 1));

  // Latched calls relative to the car, plus calls at the neighbouring floors
  always_comb begin
    above  = 1'b0;
    below  = 1'b0;
    hit_up = 1'b0;
    hit_dn = 1'b0;
    pr     = pending | req;
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (i > int'(floor)) above = above | pending[i];
      if (i < int'(floor)) below = below | pending[i];
      if (i == int'(floor) + 1) hit_up = pr[i];
      if (i == int'(floor) - 1) hit_dn = pr[i];
    end
  end

  // Scheduler: next state, timer, floor and the floor being serviced
  always_comb begin
    state_n  = state;
    dir_up_n = dir_up;
    timer_n  = timer + TW'(1);
    floor_n  = floor;
    arrive_n = 1'b0;
    svc      = '0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (pr[floor]) begin
          state_n = DOOR;
          svc     = FLOORS'(1) << floor;
        end else if (above && (dir_up || !below)) begin
          state_n  = UP;
          dir_up_n = 1'b1;
        end else if (below) begin
          state_n  = DOWN;
          dir_up_n = 1'b0;
        end
      end
      UP: begin
        if (travel_end) begin
          timer_n = '0;
          floor_n = floor + FW'(1);
          if (hit_up) begin
            state_n  = DOOR;
            svc      = FLOORS'(1) << floor_n;
            arrive_n = 1'b1;
          end
        end
      end
      DOWN: begin
        if (travel_end) begin
          timer_n = '0;
          floor_n = floor - FW'(1);
          if (hit_dn) begin
            state_n  = DOOR;
            svc      = FLOORS'(1) << floor_n;
            arrive_n = 1'b1;
          end
        end
      end
      DOOR: begin
        // calls for the open floor are absorbed and hold the door
        svc = FLOORS'(1) << floor;
        if (req[floor]) begin
          timer_n = '0;
        end else if (door_end) begin
          timer_n = '0;
          if (dir_up ? above : below) begin
            state_n = dir_up ? UP : DOWN;
          end else if (dir_up ? below : above) begin
            state_n  = dir_up ? DOWN : UP;
            dir_up_n = !dir_up;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    pending_n = pr & ~svc;
  end

  // State and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dir_up      <= 1'b1;
      timer       <= '0;
      floor       <= '0;
      pending     <= '0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
      arrive      <= 1'b0;
      done        <= 1'b1;
    end else begin
      state       <= state_n;
      dir_up      <= dir_up_n;
      timer       <= timer_n;
      floor       <= floor_n;
      pending     <= pending_n;
      moving_up   <= (state_n == UP);
      moving_down <= (state_n == DOWN);
      door_open   <= (state_n == DOOR);
      arrive      <= arrive_n;
      done        <= (state_n == IDLE) && (pending_n == '0);
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Testbench for elevator_controller: directed scenarios plus a randomized run
// checked against a behavioural model of the sweep scheduler.
module tb_elevator_controller;

  localparam int FLOORS = 10;
  localparam int TRAVEL = 4;
  localparam int DWELL  = 8;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  localparam logic [18:0] RESET_V = {4'd0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  req;
  logic [3:0]  floor;
  logic        moving_up, moving_down, door_open, arrive, done;
  logic [9:0]  pending;
  logic [18:0] obs;

  int errors = 0;
  int checks = 0;

  // behavioural model: mode, travel direction and cycles left in the current leg
  int         m_floor, m_mode, m_dir, m_left;
  logic [9:0] m_pend;
  logic       m_arrive;

  elevator_controller #(.FLOORS(FLOORS), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DWELL)) dut (
    .clk(clk), .reset(reset), .req(req), .floor(floor),
    .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open),
    .pending(pending), .arrive(arrive), .done(done)
  );

  always #5 clk = ~clk;

  assign obs = {floor, moving_up, moving_down, door_open, pending, arrive, done};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function void model_reset();
    m_floor  = 0;
    m_mode   = M_IDLE;
    m_dir    = 1;
    m_left   = 0;
    m_pend   = '0;
    m_arrive = 1'b0;
  endfunction

  function void model_step(input logic [9:0] r);
    logic [9:0] p;
    bit ab, be, ahead, behind;
    p  = m_pend | r;
    ab = (m_pend >> (m_floor + 1)) != 10'd0;
    be = (m_pend & ((10'd1 << m_floor) - 10'd1)) != 10'd0;
    m_arrive = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (p[m_floor]) begin
          p[m_floor] = 1'b0;
          m_mode = M_DOOR;
          m_left = DWELL;
        end else if (ab && (m_dir > 0 || !be)) begin
          m_mode = M_MOVE; m_dir = 1; m_left = TRAVEL;
        end else if (be) begin
          m_mode = M_MOVE; m_dir = -1; m_left = TRAVEL;
        end
      end
      M_MOVE: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_floor = m_floor + m_dir;
          if (p[m_floor]) begin
            p[m_floor] = 1'b0;
            m_mode = M_DOOR;
            m_left = DWELL;
            m_arrive = 1'b1;
          end else begin
            m_left = TRAVEL;
          end
        end
      end
      default: begin
        p[m_floor] = 1'b0;
        if (r[m_floor]) begin
          m_left = DWELL;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            ahead  = (m_dir > 0) ? ab : be;
            behind = (m_dir > 0) ? be : ab;
            if (ahead) begin
              m_mode = M_MOVE; m_left = TRAVEL;
            end else if (behind) begin
              m_mode = M_MOVE; m_left = TRAVEL; m_dir = -m_dir;
            end else begin
              m_mode = M_IDLE;
            end
          end
        end
      end
    endcase
    m_pend = p;
  endfunction

  function logic [18:0] model_vec();
    return {4'(m_floor), (m_mode == M_MOVE && m_dir > 0), (m_mode == M_MOVE && m_dir < 0),
            (m_mode == M_DOOR), m_pend, m_arrive, (m_mode == M_IDLE && m_pend == 10'd0)};
  endfunction

  // one clock: drive req, let the edge happen, advance the model, settle
  task automatic tick(input logic [9:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    req = '0;
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== RESET_V) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", obs, RESET_V);
    end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick('0);
      checks++;
      if (obs !== RESET_V) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h want %h", c, obs, RESET_V);
      end
    end
  endtask

  task automatic test_single_call();
    tick(10'h008);
    checks++;
    if (pending !== 10'h008 || moving_up !== 1'b0) begin
      errors++;
      $display("FAIL call_latch: pending=%h up=%b want 008/0", pending, moving_up);
    end
    tick('0);
    checks++;
    if (moving_up !== 1'b1 || floor !== 4'd0) begin
      errors++;
      $display("FAIL call_depart: up=%b floor=%0d want 1/0", moving_up, floor);
    end
    for (int e = 2; e <= 21; e++) begin
      tick('0);
      if (e == 5 || e == 9) begin
        checks++;
        if (floor !== 4'((e - 1) / 4) || !moving_up) begin
          errors++;
          $display("FAIL call_floor k+%0d: floor=%0d up=%b want %0d/1", e, floor, moving_up, (e - 1) / 4);
        end
      end
      if (e == 13) begin
        checks++;
        if (floor !== 4'd3 || arrive !== 1'b1 || door_open !== 1'b1 || pending !== 10'h000 || moving_up !== 1'b0) begin
          errors++;
          $display("FAIL call_arrive: floor=%0d arrive=%b door=%b pending=%h want 3/1/1/000", floor, arrive, door_open, pending);
        end
      end
      if (e == 14 || e == 20) begin
        checks++;
        if (arrive !== 1'b0 || door_open !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL call_dwell k+%0d: arrive=%b door=%b done=%b want 0/1/0", e, arrive, door_open, done);
        end
      end
      if (e == 21) begin
        checks++;
        if (done !== 1'b1 || door_open !== 1'b0 || moving_up !== 1'b0 || floor !== 4'd3) begin
          errors++;
          $display("FAIL call_idle: done=%b door=%b up=%b floor=%0d want 1/0/0/3", done, door_open, moving_up, floor);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int arr[$];
    bit reached, saw_down, finished;
    reached = 0; saw_down = 0; finished = 0;
    tick(10'h100);
    for (int c = 0; c < 100 && !reached; c++) begin
      tick('0);
      if (floor == 4'd5) reached = 1;
    end
    checks++;
    if (!reached || moving_up !== 1'b1 || pending !== 10'h100) begin
      errors++;
      $display("FAIL sweep_setup: floor=%0d up=%b pending=%h want 5/1/100", floor, moving_up, pending);
    end
    tick(10'h084);
    for (int c = 0; c < 300 && !finished; c++) begin
      tick('0);
      if (arrive) arr.push_back(int'(floor));
      if (moving_down) saw_down = 1;
      if (done) finished = 1;
    end
    checks++;
    if (!finished || arr.size() != 3 || floor !== 4'd2 || !saw_down) begin
      errors++;
      $display("FAIL sweep_order: finished=%b stops=%0d floor=%0d down=%b want 1/3/2/1", finished, arr.size(), floor, saw_down);
    end else begin
      checks++;
      if (arr[0] != 7 || arr[1] != 8 || arr[2] != 2) begin
        errors++;
        $display("FAIL sweep_stops: got %0d,%0d,%0d want 7,8,2", arr[0], arr[1], arr[2]);
      end
    end
  endtask

  task automatic test_door_restart();
    bit opened;
    opened = 0;
    tick(10'h010);
    for (int c = 0; c < 60 && !opened; c++) begin
      tick('0);
      if (door_open && floor == 4'd4) opened = 1;
    end
    checks++;
    if (!opened) begin
      errors++;
      $display("FAIL door_setup: floor=%0d door=%b want 4/1", floor, door_open);
    end
    repeat (6) tick('0);
    tick(10'h010);
    checks++;
    if (pending[4] !== 1'b0 || door_open !== 1'b1) begin
      errors++;
      $display("FAIL door_absorb: pending=%h door=%b want bit4=0 door=1", pending, door_open);
    end
    for (int c = 1; c <= 7; c++) begin
      tick('0);
      checks++;
      if (door_open !== 1'b1) begin
        errors++;
        $display("FAIL door_hold cycle %0d: door=%b want 1", c, door_open);
      end
    end
    tick('0);
    checks++;
    if (door_open !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL door_close: door=%b done=%b want 0/1", door_open, done);
    end
  endtask

  task automatic test_async_reset();
    bit reached;
    reached = 0;
    pulse_reset();
    tick(10'h0F8);
    for (int c = 0; c < 60 && !reached; c++) begin
      tick('0);
      if (floor == 4'd2) reached = 1;
    end
    tick('0);
    checks++;
    if (!reached || pending !== 10'h0F8 || moving_up !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: floor=%0d pending=%h up=%b want 2/0f8/1", floor, pending, moving_up);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== RESET_V) begin
      errors++;
      $display("FAIL areset_midcycle: got %h want %h", obs, RESET_V);
    end
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_extremes();
    int max_floor;
    max_floor = 0;
    tick(10'h201);
    checks++;
    if (door_open !== 1'b1 || pending !== 10'h200 || floor !== 4'd0) begin
      errors++;
      $display("FAIL ext_open: door=%b pending=%h floor=%0d want 1/200/0", door_open, pending, floor);
    end
    repeat (7) tick('0);
    tick('0);
    checks++;
    if (moving_up !== 1'b1 || door_open !== 1'b0) begin
      errors++;
      $display("FAIL ext_depart: up=%b door=%b want 1/0", moving_up, door_open);
    end
    for (int e = 1; e <= 36; e++) begin
      tick('0);
      if (int'(floor) > max_floor) max_floor = int'(floor);
      if (e == 35) begin
        checks++;
        if (floor !== 4'd8 || moving_up !== 1'b1) begin
          errors++;
          $display("FAIL ext_floor8: floor=%0d up=%b want 8/1", floor, moving_up);
        end
      end
    end
    checks++;
    if (floor !== 4'd9 || arrive !== 1'b1 || door_open !== 1'b1 || pending !== 10'h000) begin
      errors++;
      $display("FAIL ext_top: floor=%0d arrive=%b door=%b pending=%h want 9/1/1/000", floor, arrive, door_open, pending);
    end
    repeat (8) begin
      tick('0);
      if (int'(floor) > max_floor) max_floor = int'(floor);
    end
    checks++;
    if (max_floor > 9 || done !== 1'b1 || floor !== 4'd9) begin
      errors++;
      $display("FAIL ext_bound: max_floor=%0d done=%b floor=%0d want <=9/1/9", max_floor, done, floor);
    end
  endtask

  task automatic test_random();
    logic [9:0] r, prev;
    int roll;
    prev = '0;
    pulse_reset();
    for (int c = 0; c < 2000; c++) begin
      roll = $urandom_range(0, 11);
      r = '0;
      if (roll < 2) r = 10'd1 << $urandom_range(0, 9);
      else if (roll == 2) r = 10'($urandom) & 10'($urandom) & 10'($urandom);
      else if (roll == 3) r = prev;
      prev = r;
      tick(r);
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h want %h", c, obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_sweep();
    test_door_restart();
    test_async_reset();
    test_extremes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
